yctrl_multicycle: RTL and testbench

- Multi-cycle control FSM for the RV32 datapath (yIF/yID/yEX/yDM/yWB/yPC).
- Replaces single-cycle, bench-driven control with a synthesisable controller that sequences fetch, decode, execute, memory and write-back.
- Adds a memory ready handshake with timeout, a precise interrupt entry, illegal-opcode trapping and a retired-instruction counter.
- Sits beside the datapath; drives all of its control strobes and the PC-source mux.

---
 rtl/yctrl_pkg.sv | 44 ++++
 rtl/yctrl_multicycle_if.sv | 26 ++
 rtl/yctrl_multicycle_alu_dec.sv | 31 +++
 rtl/yctrl_multicycle.sv | 138 +++++++++++++
 tb/tb_yctrl_multicycle.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/yctrl_pkg.sv
// Shared encodings for the multi-cycle RV32 controller: FSM states, opcodes,
// ALU op codes and datapath mux selects.
package yctrl_pkg;

  typedef enum logic [2:0] {
    S_ENTRY  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [6:0] OP_R  = 7'h33;
  localparam logic [6:0] OP_I  = 7'h13;
  localparam logic [6:0] OP_LW = 7'h03;
  localparam logic [6:0] OP_SW = 7'h23;
  localparam logic [6:0] OP_SB = 7'h63;
  localparam logic [6:0] OP_UJ = 7'h6f;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {
    PC_P4     = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2,
    PC_ENTRY  = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  function automatic logic is_legal(input logic [6:0] opcode);
    return (opcode == OP_R)  || (opcode == OP_I)  || (opcode == OP_LW) ||
           (opcode == OP_SW) || (opcode == OP_SB) || (opcode == OP_UJ);
  endfunction

endpackage

// File: rtl/yctrl_multicycle_if.sv
// Controller <-> datapath bundle: instruction/status inputs and control strobes.
interface yctrl_multicycle_if;
  logic [31:0] ins;
  logic        zero;
  logic        mem_ready;
  logic        int_req;
  logic        ir_write;
  logic        RegWrite;
  logic        ALUSrc;
  logic [2:0]  op;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic [1:0]  pc_sel;

  modport master (
    input  ins, zero, mem_ready, int_req,
    output ir_write, RegWrite, ALUSrc, op, MemRead, MemWrite, wb_sel, pc_write, pc_sel
  );

  modport slave (
    output ins, zero, mem_ready, int_req,
    input  ir_write, RegWrite, ALUSrc, op, MemRead, MemWrite, wb_sel, pc_write, pc_sel
  );
endinterface

// File: rtl/yctrl_multicycle_alu_dec.sv
// Combinational ALU control decoder: opcode/funct3/funct7[5] to ALU op and
// operand-B select. Shared by EXEC and MEM so the address stays stable.
module yctrl_alu_dec
  import yctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  output logic [2:0] op,
  output logic       alu_src
);

  always_comb begin
    op      = ALU_ADD;
    alu_src = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          3'b000:  op = funct7_b5 ? ALU_SUB : ALU_ADD;
          3'b110:  op = ALU_OR;
          3'b111:  op = ALU_AND;
          default: op = ALU_ADD;
        endcase
      end
      OP_I, OP_LW, OP_SW: alu_src = 1'b1;
      OP_SB:              op      = ALU_SUB;
      default: ;
    endcase
  end

endmodule

// File: rtl/yctrl_multicycle.sv
// Multi-cycle control FSM for the RV32 datapath: sequences fetch/decode/execute/
// memory/write-back with memory timeout, interrupt entry and illegal-op traps.
module yctrl_multicycle
  import yctrl_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic                clk,
  input  logic                reset,
  yctrl_multicycle_if.master  bus,
  output logic [2:0]          state,
  output logic                illegal,
  output logic                timeout,
  output logic [XLEN-1:0]     instr_count
);

  state_t           cur;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opcode;
  logic [2:0]       dec_op;
  logic             dec_alu_src;

  assign opcode = bus.ins[6:0];
  assign state  = cur;

  yctrl_alu_dec u_alu_dec (
    .opcode    (opcode),
    .funct3    (bus.ins[14:12]),
    .funct7_b5 (bus.ins[30]),
    .op        (dec_op),
    .alu_src   (dec_alu_src)
  );

  // NOTE: every output gets a default before the case so no path can hold a stale value (no latch).
  always_comb begin
    bus.ir_write = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.op       = ALU_ADD;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.wb_sel   = WB_ALU;
    bus.pc_write = 1'b0;
    bus.pc_sel   = PC_P4;
    case (cur)
      S_ENTRY: begin
        bus.pc_write = 1'b1;
        bus.pc_sel   = PC_ENTRY;
      end
      S_FETCH: bus.ir_write = !bus.int_req;
      S_EXEC: begin
        bus.op     = dec_op;
        bus.ALUSrc = dec_alu_src;
        if (opcode == OP_SB) begin
          bus.pc_write = 1'b1;
          bus.pc_sel   = bus.zero ? PC_BRANCH : PC_P4;
        end
      end
      S_MEM: begin
        bus.op       = dec_op;
        bus.ALUSrc   = dec_alu_src;
        bus.MemRead  = (opcode == OP_LW);
        bus.MemWrite = (opcode == OP_SW);
        // A store retires in MEM as soon as the memory accepts it.
        if (opcode == OP_SW && bus.mem_ready) bus.pc_write = 1'b1;
      end
      S_WB: begin
        bus.RegWrite = 1'b1;
        bus.pc_write = 1'b1;
        if (opcode == OP_LW)      bus.wb_sel = WB_MEM;
        else if (opcode == OP_UJ) bus.wb_sel = WB_PC4;
        if (opcode == OP_UJ)      bus.pc_sel = PC_JUMP;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur         <= S_ENTRY;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      case (cur)
        S_ENTRY: cur <= S_FETCH;
        S_FETCH: cur <= bus.int_req ? S_ENTRY : S_DECODE;
        S_DECODE: begin
          if (is_legal(opcode)) begin
            cur <= S_EXEC;
          end else begin
            illegal <= 1'b1;
            cur     <= S_ENTRY;
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_SB: begin
              instr_count <= instr_count + XLEN'(1);
              cur         <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              wait_cnt <= '0;
              cur      <= S_MEM;
            end
            default: cur <= S_WB;
          endcase
        end
        S_MEM: begin
          // Ready wins over expiry, so a response on the last allowed cycle still succeeds.
          if (bus.mem_ready) begin
            if (opcode == OP_LW) begin
              cur <= S_WB;
            end else begin
              instr_count <= instr_count + XLEN'(1);
              cur         <= S_FETCH;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            timeout <= 1'b1;
            cur     <= S_ENTRY;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_WB: begin
          instr_count <= instr_count + XLEN'(1);
          cur         <= S_FETCH;
        end
        default: cur <= S_ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_yctrl_multicycle.sv
// Directed bench for yctrl_multicycle: a table of per-cycle vectors for the
// straight-line instructions plus hand-written memory, trap and interrupt sequences.
module tb_yctrl_multicycle;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       rw;
    logic       asrc;
    logic [2:0] op;
    logic       mr;
    logic       mw;
    logic [1:0] wbs;
    logic       pcw;
    logic [1:0] pcs;
  } ctrl_t;

  typedef struct {
    logic [31:0] ins;
    logic        zero;
    logic        rdy;
    logic        irq;
    ctrl_t       exp;
    logic [31:0] cnt;
    logic        ill;
    logic        to;
  } vec_t;

  localparam logic [31:0] I_ADD  = 32'h002081b3;
  localparam logic [31:0] I_SUB  = 32'h402081b3;
  localparam logic [31:0] I_AND  = 32'h0020f1b3;
  localparam logic [31:0] I_OR   = 32'h0020e1b3;
  localparam logic [31:0] I_ADDI = 32'h00508193;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h0080006f;
  localparam logic [31:0] I_LW   = 32'h0000a183;
  localparam logic [31:0] I_SW   = 32'h0030a223;
  localparam logic [31:0] I_BAD  = 32'h0000007f;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  state;
  logic        illegal;
  logic        timeout;
  logic [31:0] instr_count;
  int          total = 0;
  int          bad   = 0;
  int          mr_cycles = 0;
  int          mw_cycles = 0;
  vec_t        tbl[$];

  yctrl_multicycle_if bus ();

  yctrl_multicycle #(.XLEN(32), .TIMEOUT(15), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .state       (state),
    .illegal     (illegal),
    .timeout     (timeout),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  function automatic ctrl_t ctl(input logic [2:0] st, input logic irw, rw, asrc,
                                input logic [2:0] op, input logic mr, mw,
                                input logic [1:0] wbs, input logic pcw,
                                input logic [1:0] pcs);
    ctrl_t c;
    c = '{st: st, irw: irw, rw: rw, asrc: asrc, op: op, mr: mr, mw: mw,
          wbs: wbs, pcw: pcw, pcs: pcs};
    return c;
  endfunction

  function automatic ctrl_t c_entry();         return ctl(0, 0, 0, 0, 3'b010, 0, 0, 0, 1, 3); endfunction
  function automatic ctrl_t c_fetch();         return ctl(1, 1, 0, 0, 3'b010, 0, 0, 0, 0, 0); endfunction
  function automatic ctrl_t c_fetch_irq();     return ctl(1, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0); endfunction
  function automatic ctrl_t c_dec();           return ctl(2, 0, 0, 0, 3'b010, 0, 0, 0, 0, 0); endfunction
  function automatic ctrl_t c_exec(input logic asrc, input logic [2:0] op);
    return ctl(3, 0, 0, asrc, op, 0, 0, 0, 0, 0);
  endfunction
  function automatic ctrl_t c_beq(input logic [1:0] pcs);
    return ctl(3, 0, 0, 0, 3'b110, 0, 0, 0, 1, pcs);
  endfunction
  function automatic ctrl_t c_mem(input logic mr, mw, pcw);
    return ctl(4, 0, 0, 1, 3'b010, mr, mw, 0, pcw, 0);
  endfunction
  function automatic ctrl_t c_wb(input logic [1:0] wbs, input logic [1:0] pcs);
    return ctl(5, 0, 1, 0, 3'b010, 0, 0, wbs, 1, pcs);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drive one cycle of inputs, compare combinational strobes and registered status, advance.
  task automatic step(input string tag, input logic [31:0] ins, input logic z, r, irq,
                      input ctrl_t exp, input logic [31:0] cnt, input logic ill, to);
    ctrl_t act;
    bus.ins = ins;
    bus.zero = z;
    bus.mem_ready = r;
    bus.int_req = irq;
    #1;
    act = ctl(state, bus.ir_write, bus.RegWrite, bus.ALUSrc, bus.op, bus.MemRead,
              bus.MemWrite, bus.wb_sel, bus.pc_write, bus.pc_sel);
    check({tag, " ctrl"}, 64'(act), 64'(exp));
    check({tag, " status"}, {30'd0, illegal, timeout, instr_count}, {30'd0, ill, to, cnt});
    if (bus.MemRead)  mr_cycles++;
    if (bus.MemWrite) mw_cycles++;
    tick();
  endtask

  task automatic push(input logic [31:0] ins, input logic z, input ctrl_t exp,
                      input logic [31:0] cnt);
    vec_t v;
    v = '{ins: ins, zero: z, rdy: 1'b0, irq: 1'b0, exp: exp, cnt: cnt, ill: 1'b0, to: 1'b0};
    tbl.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    push(I_ADD,  0, c_entry(),          0);
    push(I_ADD,  0, c_fetch(),          0);
    push(I_ADD,  0, c_dec(),            0);
    push(I_ADD,  0, c_exec(0, 3'b010),  0);
    push(I_ADD,  0, c_wb(0, 0),         0);
    push(I_SUB,  0, c_fetch(),          1);
    push(I_SUB,  0, c_dec(),            1);
    push(I_SUB,  0, c_exec(0, 3'b110),  1);
    push(I_SUB,  0, c_wb(0, 0),         1);
    push(I_AND,  0, c_fetch(),          2);
    push(I_AND,  0, c_dec(),            2);
    push(I_AND,  0, c_exec(0, 3'b000),  2);
    push(I_AND,  0, c_wb(0, 0),         2);
    push(I_OR,   0, c_fetch(),          3);
    push(I_OR,   0, c_dec(),            3);
    push(I_OR,   0, c_exec(0, 3'b001),  3);
    push(I_OR,   0, c_wb(0, 0),         3);
    push(I_ADDI, 0, c_fetch(),          4);
    push(I_ADDI, 0, c_dec(),            4);
    push(I_ADDI, 0, c_exec(1, 3'b010),  4);
    push(I_ADDI, 0, c_wb(0, 0),         4);
    push(I_BEQ,  1, c_fetch(),          5);
    push(I_BEQ,  1, c_dec(),            5);
    push(I_BEQ,  1, c_beq(1),           5);
    push(I_BEQ,  0, c_fetch(),          6);
    push(I_BEQ,  0, c_dec(),            6);
    push(I_BEQ,  0, c_beq(0),           6);
    push(I_JAL,  0, c_fetch(),          7);
    push(I_JAL,  0, c_dec(),            7);
    push(I_JAL,  0, c_exec(0, 3'b010),  7);
    push(I_JAL,  0, c_wb(2, 2),         7);

    reset = 1'b1;
    bus.ins = I_ADD;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    bus.int_req = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    foreach (tbl[i])
      step($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].zero, tbl[i].rdy, tbl[i].irq,
           tbl[i].exp, tbl[i].cnt, tbl[i].ill, tbl[i].to);

    // lw with three wait cycles: MemRead held four cycles, eight cycles FETCH to WB.
    mr_cycles = 0;
    step("lw fetch", I_LW, 0, 0, 0, c_fetch(), 8, 0, 0);
    step("lw dec",   I_LW, 0, 0, 0, c_dec(),   8, 0, 0);
    step("lw exec",  I_LW, 0, 0, 0, c_exec(1, 3'b010), 8, 0, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("lw wait%0d", i), I_LW, 0, 0, 0, c_mem(1, 0, 0), 8, 0, 0);
    step("lw ready", I_LW, 0, 1, 0, c_mem(1, 0, 0), 8, 0, 0);
    step("lw wb",    I_LW, 0, 0, 0, c_wb(1, 0), 8, 0, 0);
    check("lw memread cycles", 64'(mr_cycles), 64'd4);

    // sw answered on exactly the TIMEOUT cycle retires normally.
    step("swb fetch", I_SW, 0, 0, 0, c_fetch(), 9, 0, 0);
    step("swb dec",   I_SW, 0, 0, 0, c_dec(),   9, 0, 0);
    step("swb exec",  I_SW, 0, 0, 0, c_exec(1, 3'b010), 9, 0, 0);
    for (int i = 0; i < 15; i++)
      step($sformatf("swb wait%0d", i), I_SW, 0, 0, 0, c_mem(0, 1, 0), 9, 0, 0);
    step("swb ready", I_SW, 0, 1, 0, c_mem(0, 1, 1), 9, 0, 0);

    // sw never answered: sixteen MemWrite cycles, then timeout trap to ENTRY.
    mw_cycles = 0;
    step("swt fetch", I_SW, 0, 0, 0, c_fetch(), 10, 0, 0);
    step("swt dec",   I_SW, 0, 0, 0, c_dec(),   10, 0, 0);
    step("swt exec",  I_SW, 0, 0, 0, c_exec(1, 3'b010), 10, 0, 0);
    for (int i = 0; i < 16; i++)
      step($sformatf("swt wait%0d", i), I_SW, 0, 0, 0, c_mem(0, 1, 0), 10, 0, 0);
    check("sw timeout memwrite cycles", 64'(mw_cycles), 64'd16);
    step("swt entry", I_SW, 0, 0, 0, c_entry(), 10, 0, 1);

    // Interrupt raised mid-instruction: addi completes, next FETCH diverts to ENTRY.
    step("irq fetch", I_ADDI, 0, 0, 0, c_fetch(), 10, 0, 1);
    step("irq dec",   I_ADDI, 0, 0, 0, c_dec(),   10, 0, 1);
    step("irq exec",  I_ADDI, 0, 0, 1, c_exec(1, 3'b010), 10, 0, 1);
    step("irq wb",    I_ADDI, 0, 0, 1, c_wb(0, 0), 10, 0, 1);
    step("irq fetch2", I_ADDI, 0, 0, 1, c_fetch_irq(), 11, 0, 1);
    step("irq entry", I_ADDI, 0, 0, 0, c_entry(), 11, 0, 1);

    // Illegal opcode traps from DECODE without retiring.
    step("ill fetch", I_BAD, 0, 0, 0, c_fetch(), 11, 0, 1);
    step("ill dec",   I_BAD, 0, 0, 0, c_dec(),   11, 0, 1);
    step("ill entry", I_BAD, 0, 0, 0, c_entry(), 11, 1, 1);

    // Reset while a load is waiting in MEM abandons the access and clears everything.
    step("rst fetch", I_LW, 0, 0, 0, c_fetch(), 11, 1, 1);
    step("rst dec",   I_LW, 0, 0, 0, c_dec(),   11, 1, 1);
    step("rst exec",  I_LW, 0, 0, 0, c_exec(1, 3'b010), 11, 1, 1);
    reset = 1'b1;
    step("rst mem",   I_LW, 0, 0, 0, c_mem(1, 0, 0), 11, 1, 1);
    reset = 1'b0;
    step("rst entry", I_LW, 0, 0, 0, c_entry(), 0, 0, 0);
    step("rst fetch2", I_LW, 0, 0, 0, c_fetch(), 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
